// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// fetch stage (read-only, port I) and the memory stage (read/write, port D).
// Each access takes IDLE -> ISSUE -> RESP; D has priority unless fetch has
// lost STARVE_LIM consecutive contended arbitrations.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_W     = 11,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // fetch port
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  // data port
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  // memory side
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wd,
  input  logic [WORD_SIZE-1:0] mem_rd,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  localparam logic [3:0] LIM   = 4'(STARVE_LIM);
  localparam logic       OWN_I = 1'b0;
  localparam logic       OWN_D = 1'b1;

  state_e                state_q, state_d;
  logic                  owner_q;
  logic                  op_q;        // 1 = write
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic [3:0]            starve_q, starve_d;
  logic                  mem_read_q, mem_write_q;
  logic [WORD_SIZE-1:0]  i_rdata_q, d_rdata_q;

  logic contend, force_i, grant_i, grant_d, win;

  // Arbitration on the raw request lines; only acted upon in IDLE
  always_comb begin
    contend = i_req & d_req;
    force_i = (starve_q >= LIM);
    grant_d = d_req & ~(contend & force_i);
    grant_i = i_req & ~grant_d;
    win     = grant_i | grant_d;
  end

  // Starvation counter: counts contended D wins, cleared when fetch is
  // granted or when fetch is not asking at all
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_i || !i_req)
        starve_d = 4'd0;
      else if (contend && grant_d && starve_q != 4'hF)
        starve_d = starve_q + 4'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: every granted access runs exactly ISSUE then RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latching and memory strobes; strobes are flops so that mem_* never
  // sees a combinational path from the request inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_I;
      op_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= 4'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if (state_q == IDLE && win) begin
        owner_q     <= grant_d ? OWN_D : OWN_I;
        op_q        <= grant_d & d_we;
        addr_q      <= grant_d ? d_addr : i_addr;
        wdata_q     <= d_wdata;
        mem_read_q  <= ~(grant_d & d_we);
        mem_write_q <= grant_d & d_we;
      end
    end
  end

  // Hold each port's last returned word once its ack cycle is over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (state_q == RESP) begin
      if (owner_q == OWN_I)
        i_rdata_q <= mem_rd;
      else if (!op_q)
        d_rdata_q <= mem_rd;
    end
  end

  // FSM outputs: ack to the owner during RESP, read data straight from memory
  always_comb begin
    busy      = (state_q != IDLE);
    i_ack     = (state_q == RESP) && (owner_q == OWN_I);
    d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    i_rdata   = i_ack ? mem_rd : i_rdata_q;
    d_rdata   = d_ack ? mem_rd : d_rdata_q;
    mem_read  = mem_read_q;
    mem_write = mem_write_q;
    mem_addr  = addr_q;
    mem_wd    = wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, reference memory model and
// per-port queues of expected read data compared when each ack appears.
module tb_mem_port_arbiter;

  localparam int WS = 16;
  localparam int AW = 11;

  logic          gclk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [WS-1:0] d_wdata;
  logic          i_ack, d_ack, mem_read, mem_write, busy;
  logic [WS-1:0] i_rdata, d_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.WORD_SIZE(WS), .ADDR_W(AW), .STARVE_LIM(4)) dut (
    .clk(gclk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  always #5 gclk = ~gclk;

  // single-port synchronous memory, with a bench-side preload path
  logic [WS-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [WS-1:0] pre_d  = '0;
  always @(posedge gclk) begin
    if (pre_we)         mem[pre_a]    <= pre_d;
    else if (mem_write) mem[mem_addr] <= mem_wd;
    if (mem_read)       mem_rd        <= mem[mem_addr];
  end

  int            errs = 0;
  int            nchk = 0;
  logic [WS-1:0] ref_mem [int];
  logic [WS-1:0] iq [$];
  logic [WS:0]   dq [$];   // {compare, value}; writes push compare=0
  logic          got_q [$]; // ack order, 1 = D

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // advance to the next falling edge and score any ack seen there
  task automatic tick();
    logic [WS:0] e;
    @(negedge gclk);
    if (mem_read || mem_write) chk("rw_excl", 32'(mem_read & mem_write), 0);
    if (i_ack) begin
      got_q.push_back(1'b0);
      chk("i_sb_empty", 32'(iq.size() == 0), 0);
      if (iq.size() != 0) chk("i_rdata", 32'(i_rdata), 32'(iq.pop_front()));
    end
    if (d_ack) begin
      got_q.push_back(1'b1);
      chk("d_sb_empty", 32'(dq.size() == 0), 0);
      if (dq.size() != 0) begin
        e = dq.pop_front();
        if (e[WS]) chk("d_rdata", 32'(d_rdata), 32'(e[WS-1:0]));
      end
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WS-1:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge gclk);
    pre_we = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  task automatic push_d(input logic we, input logic [AW-1:0] a, input logic [WS-1:0] wd);
    if (we) begin
      dq.push_back({1'b0, wd});
      ref_mem[int'(a)] = wd;
    end else begin
      dq.push_back({1'b1, ref_mem[int'(a)]});
    end
  endtask

  // one uncontended D access with exact-latency checks; mut changes the
  // request inputs during ISSUE to prove the latched copies are used
  task automatic d_access(input logic we, input logic [AW-1:0] a,
                          input logic [WS-1:0] wd, input logic mut);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    push_d(we, a, wd);
    tick();  // ISSUE
    if (mut) begin
      d_addr = ~a; d_wdata = ~wd;
      #1;
    end
    chk("iss_rd", 32'(mem_read), 32'(!we));
    chk("iss_wr", 32'(mem_write), 32'(we));
    chk("iss_addr", 32'(mem_addr), 32'(a));
    if (we) chk("iss_wd", 32'(mem_wd), 32'(wd));
    tick();  // RESP
    chk("d_ack", 32'(d_ack), 1);
    chk("i_ack_q", 32'(i_ack), 0);
    d_req = 1'b0;
    tick();
    chk("d_ack_pulse", 32'(d_ack), 0);
  endtask

  initial begin
    bit done_i, done_d;
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 11'h012; d_addr = 11'h100; d_wdata = '0;

    // reset: preload while held, everything must be quiet
    preload(11'h012, 16'hBEEF);
    preload(11'h100, 16'h5A5A);
    preload(11'h7FF, 16'h0000);
    tick();
    chk("rst_i_ack", 32'(i_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_i_rdata", 32'(i_rdata), 0);
    chk("rst_d_rdata", 32'(d_rdata), 0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wd", 32'(mem_wd), 0);
    chk("rst_busy", 32'(busy), 0);

    // release with both requesting: D first, then I
    got_q.delete();
    push_d(1'b0, 11'h100, '0);
    iq.push_back(ref_mem[int'(11'h012)]);
    rst = 1'b1;
    done_i = 0; done_d = 0;
    for (int n = 0; n < 30 && !(done_i && done_d); n++) begin
      tick();
      if (d_ack) begin d_req = 1'b0; done_d = 1; end
      if (i_ack) begin i_req = 1'b0; done_i = 1; end
    end
    chk("rel_done", {30'd0, done_i, done_d}, 3);
    chk("rel_n", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("rel_first", 32'(got_q[0]), 1);
      chk("rel_second", 32'(got_q[1]), 0);
    end
    tick();

    // single fetch with exact latency
    i_addr = 11'h012; i_req = 1'b1;
    iq.push_back(16'hBEEF);
    tick();
    chk("f_mem_read", 32'(mem_read), 1);
    chk("f_mem_addr", 32'(mem_addr), 32'h012);
    chk("f_busy", 32'(busy), 1);
    tick();
    chk("f_i_ack", 32'(i_ack), 1);
    chk("f_d_ack", 32'(d_ack), 0);
    chk("f_mem_read_off", 32'(mem_read), 0);
    i_req = 1'b0;
    tick();
    chk("f_ack_pulse", 32'(i_ack), 0);
    chk("f_hold", 32'(i_rdata), 32'hBEEF);
    chk("f_idle", 32'(busy), 0);

    // write then read at the top address
    d_access(1'b1, 11'h7FF, 16'h1234, 1'b0);
    d_access(1'b0, 11'h7FF, '0, 1'b0);

    // inputs changed after grant must not reach memory
    d_access(1'b1, 11'h055, 16'hAAAA, 1'b1);
    d_access(1'b0, 11'h055, '0, 1'b0);

    // contention: D,D,D,D,I repeating
    got_q.delete();
    i_addr = 11'h012; d_addr = 11'h100; d_we = 1'b0;
    for (int k = 0; k < 8; k++) push_d(1'b0, 11'h100, '0);
    for (int k = 0; k < 2; k++) iq.push_back(ref_mem[int'(11'h012)]);
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 60 && got_q.size() < 10; n++) tick();
    i_req = 1'b0; d_req = 1'b0;
    chk("cont_n", 32'(got_q.size()), 10);
    for (int k = 0; k < 10 && k < got_q.size(); k++)
      chk($sformatf("cont_ord%0d", k), 32'(got_q[k]), (k % 5 == 4) ? 0 : 1);
    tick(); tick();
    chk("cont_idle", 32'(busy), 0);

    // reset during RESP abandons the ack; held request is then re-served
    d_we = 1'b0; d_addr = 11'h7FF; d_req = 1'b1;
    push_d(1'b0, 11'h7FF, '0);
    push_d(1'b0, 11'h7FF, '0);
    tick();
    tick();
    chk("mr_d_ack", 32'(d_ack), 1);
    rst = 1'b0;
    #1;
    chk("mr_ack_drop", 32'(d_ack), 0);
    chk("mr_busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    done_d = 0;
    for (int n = 0; n < 20 && !done_d; n++) begin
      tick();
      if (d_ack) begin d_req = 1'b0; done_d = 1; end
    end
    chk("mr_reack", 32'(done_d), 1);
    chk("mr_sb_drained", 32'(dq.size()), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
